// File: rtl/rsa_decrypt_seq.sv
// rsa_decrypt_seq
// Sequential RSA receive-side engine. Takes a ciphertext C and key (d, n)
// over a valid/ready handshake and returns M = C^d mod n. Uses constant-time,
// MSB-first square-and-multiply. Only one transaction is in flight at a time.
//
// Optional feature macro: RSA_VERIFY_EN
//   When defined, the engine re-encrypts M with exponent e once the result
//   is known. It flags verify_fail when M^e mod n != C.
//   When undefined, verify_fail is tied low and e is ignored.
//
// Ports
//   clk          in   1  rising-edge clock
//   reset        in   1  asynchronous active-high reset
//   in_valid     in   1  C/d/n/e valid
//   in_ready     out  1  engine idle and able to accept
//   C            in   W  ciphertext
//   d            in   W  private exponent
//   n            in   W  modulus
//   e            in   W  public exponent (verify build only)
//   out_valid    out  1  result valid
//   out_ready    in   1  downstream accepts result
//   decrypted_M  out  W  plaintext result
//   err          out  1  operand error (n<2 or C>=n)
//   verify_fail  out  1  re-encryption mismatch
//   busy         out  1  engine not idle
module rsa_decrypt_seq #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] C,
    input  logic [W-1:0] d,
    input  logic [W-1:0] n,
    input  logic [W-1:0] e,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] decrypted_M,
    output logic         err,
    output logic         verify_fail,
    output logic         busy
);

    localparam int IW = (W > 1) ? $clog2(W) : 1;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LOAD = 3'd1;
    localparam logic [2:0] SQR  = 3'd2;
    localparam logic [2:0] MUL  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;
`ifdef RSA_VERIFY_EN
    localparam logic [2:0] VSQR = 3'd5;
    localparam logic [2:0] VMUL = 3'd6;
    localparam logic [2:0] VCHK = 3'd7;
`endif

    logic [2:0]    state;
    logic [W-1:0]  c_reg;
    logic [W-1:0]  n_reg;
    logic [W-1:0]  exp_reg;
    logic [W-1:0]  acc;
    logic [W-1:0]  base;
    logic [W-1:0]  result;
    logic [IW-1:0] bit_idx;

`ifdef RSA_VERIFY_EN
    logic [W-1:0]  e_reg;
`else
    logic          unused_e;
    assign unused_e = ^e;
`endif

    // Products are formed at full 2*W width before reduction, so nothing is lost.
    logic [2*W-1:0] n_wide;
    logic [2*W-1:0] sq_prod;
    logic [2*W-1:0] mul_prod;
    logic [W-1:0]   sq_mod;
    logic [W-1:0]   mul_mod;
    logic [W-1:0]   mul_next;
    logic           operand_bad;

    assign n_wide      = {{W{1'b0}}, n_reg};
    assign sq_prod     = {{W{1'b0}}, acc} * {{W{1'b0}}, acc};
    assign mul_prod    = {{W{1'b0}}, acc} * {{W{1'b0}}, base};
    assign sq_mod      = W'(sq_prod % n_wide);
    assign mul_mod     = W'(mul_prod % n_wide);
    // The multiply is always evaluated; the exponent bit only picks whether it is kept.
    assign mul_next    = exp_reg[bit_idx] ? mul_mod : acc;
    assign operand_bad = (n_reg < W'(2)) || (c_reg >= n_reg);

    assign in_ready    = (state == IDLE);
    assign busy        = (state != IDLE);
    assign out_valid   = (state == DONE);
    assign decrypted_M = result;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            c_reg       <= '0;
            n_reg       <= '0;
            exp_reg     <= '0;
            acc         <= '0;
            base        <= '0;
            result      <= '0;
            bit_idx     <= '0;
            err         <= 1'b0;
            verify_fail <= 1'b0;
`ifdef RSA_VERIFY_EN
            e_reg       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        c_reg       <= C;
                        n_reg       <= n;
                        exp_reg     <= d;
`ifdef RSA_VERIFY_EN
                        e_reg       <= e;
`endif
                        result      <= '0;
                        err         <= 1'b0;
                        verify_fail <= 1'b0;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    acc     <= W'(1);
                    base    <= c_reg;
                    bit_idx <= IW'(W - 1);
                    err     <= operand_bad;
                    state   <= SQR;
                end
                // A flagged operand error uses the first SQR slot as its exit,
                // which gives the error result its fixed two-cycle latency.
                SQR: begin
                    if (err) begin
                        state <= DONE;
                    end else begin
                        acc   <= sq_mod;
                        state <= MUL;
                    end
                end
                MUL: begin
                    acc <= mul_next;
                    if (bit_idx == '0) begin
                        result <= mul_next;
`ifdef RSA_VERIFY_EN
                        acc     <= W'(1);
                        base    <= mul_next;
                        exp_reg <= e_reg;
                        bit_idx <= IW'(W - 1);
                        state   <= VSQR;
`else
                        state  <= DONE;
`endif
                    end else begin
                        bit_idx <= bit_idx - IW'(1);
                        state   <= SQR;
                    end
                end
`ifdef RSA_VERIFY_EN
                VSQR: begin
                    acc   <= sq_mod;
                    state <= VMUL;
                end
                VMUL: begin
                    acc <= mul_next;
                    if (bit_idx == '0) begin
                        state <= VCHK;
                    end else begin
                        bit_idx <= bit_idx - IW'(1);
                        state   <= VSQR;
                    end
                end
                VCHK: begin
                    verify_fail <= (acc != c_reg);
                    state       <= DONE;
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_decrypt_seq.sv
// tb_rsa_decrypt_seq
// Directed self-checking bench for rsa_decrypt_seq (W=7). Expected results
// are hand-computed modular exponentiations. Latency is counted in clock
// edges after the accept edge.
module tb_rsa_decrypt_seq;

    localparam int W = 7;
`ifdef RSA_VERIFY_EN
    localparam int LAT = 4 * W + 2;
`else
    localparam int LAT = 2 * W + 1;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] C, d, n, e;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] decrypted_M;
    logic         err;
    logic         verify_fail;
    logic         busy;

    int tests_run    = 0;
    int tests_failed = 0;

    rsa_decrypt_seq #(.W(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .C(C), .d(d), .n(n), .e(e), .out_valid(out_valid), .out_ready(out_ready),
        .decrypted_M(decrypted_M), .err(err), .verify_fail(verify_fail), .busy(busy)
    );

    always #5 clk = ~clk;

    // Present one transaction; it is accepted on the next rising edge.
    task automatic send(input logic [W-1:0] c_v, d_v, n_v, e_v);
        @(negedge clk);
        C = c_v; d = d_v; n = n_v; e = e_v;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        C = '0; d = '0; n = '0; e = '0;
    endtask

    // Edges after the accept edge until out_valid is seen (bounded).
    task automatic wait_result(output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        tests_run++;
        if ({in_ready, out_valid, busy, err, verify_fail, decrypted_M} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0}) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: got rdy=%b ov=%b busy=%b err=%b vf=%b M=%0d, want 1 0 0 0 0 0",
                     in_ready, out_valid, busy, err, verify_fail, decrypted_M);
        end
    endtask

    task automatic test_vectors();
        logic [W-1:0] vc [4] = '{7'd31, 7'd8, 7'd5, 7'd0};
        logic [W-1:0] vd [4] = '{7'd7, 7'd7, 7'd0, 7'd7};
        logic [W-1:0] vm [4] = '{7'd4, 7'd2, 7'd1, 7'd0};
        int cyc;
        for (int k = 0; k < 4; k++) begin
            send(vc[k], vd[k], 7'd33, 7'd3);
            tests_run++;
            if (busy !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL busy_%0d: got %b want 1", k, busy);
            end
            wait_result(cyc);
            tests_run++;
            if (cyc !== LAT) begin
                tests_failed++;
                $display("[TB] FAIL latency_%0d: got %0d want %0d", k, cyc, LAT);
            end
            tests_run++;
            if (decrypted_M !== vm[k] || err !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL result_%0d: got M=%0d err=%b want M=%0d err=0", k, decrypted_M, err, vm[k]);
            end
            handshake();
        end
    endtask

    task automatic test_errors();
        logic [W-1:0] vc [2] = '{7'd0, 7'd40};
        logic [W-1:0] vn [2] = '{7'd1, 7'd33};
        int cyc;
        for (int k = 0; k < 2; k++) begin
            send(vc[k], 7'd7, vn[k], 7'd3);
            wait_result(cyc);
            tests_run++;
            if (cyc !== 2) begin
                tests_failed++;
                $display("[TB] FAIL err_latency_%0d: got %0d want 2", k, cyc);
            end
            tests_run++;
            if (err !== 1'b1 || decrypted_M !== 7'd0 || verify_fail !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL err_result_%0d: got err=%b M=%0d vf=%b want 1 0 0", k, err, decrypted_M, verify_fail);
            end
            handshake();
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        send(7'd31, 7'd7, 7'd33, 7'd3);
        wait_result(cyc);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            C = 7'd8; d = 7'd7; n = 7'd33; e = 7'd3;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            tests_run++;
            if (out_valid !== 1'b1 || decrypted_M !== 7'd4 || err !== 1'b0 || in_ready !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL hold_%0d: got ov=%b M=%0d err=%b rdy=%b want 1 4 0 0",
                         k, out_valid, decrypted_M, err, in_ready);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        handshake();
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL after_handshake: got ov=%b rdy=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL no_stale_accept: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_abort();
        int cyc;
        send(7'd31, 7'd7, 7'd33, 7'd3);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort_state: got ov=%b rdy=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        send(7'd31, 7'd7, 7'd33, 7'd3);
        wait_result(cyc);
        tests_run++;
        if (cyc !== LAT || decrypted_M !== 7'd4) begin
            tests_failed++;
            $display("[TB] FAIL after_abort: got lat=%0d M=%0d want lat=%0d M=4", cyc, decrypted_M, LAT);
        end
        handshake();
    endtask

    task automatic test_verify();
        logic [W-1:0] vd [2] = '{7'd7, 7'd5};
        logic [W-1:0] vm [2] = '{7'd4, 7'd1};
`ifdef RSA_VERIFY_EN
        logic         vf [2] = '{1'b0, 1'b1};
`else
        logic         vf [2] = '{1'b0, 1'b0};
`endif
        int cyc;
        for (int k = 0; k < 2; k++) begin
            send(7'd31, vd[k], 7'd33, 7'd3);
            wait_result(cyc);
            tests_run++;
            if (cyc !== LAT || decrypted_M !== vm[k] || verify_fail !== vf[k]) begin
                tests_failed++;
                $display("[TB] FAIL verify_%0d: got lat=%0d M=%0d vf=%b want lat=%0d M=%0d vf=%b",
                         k, cyc, decrypted_M, verify_fail, LAT, vm[k], vf[k]);
            end
            handshake();
        end
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        C = '0; d = '0; n = '0; e = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_vectors();
        test_errors();
        test_backpressure();
        test_reset_abort();
        test_verify();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
